// File: rtl/shiftrow_if.sv
// Handshake bundle for the shiftrow_pipe row-permutation stage.
// The master side produces blocks and consumes results; the slave side is the stage itself.
interface shiftrow_if #(
  parameter int NB    = 4,
  parameter int TAG_W = 8
) ();
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_mode;
  logic [0:32*NB-1]    in_state;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [0:32*NB-1]    out_state;
  logic [TAG_W-1:0]    out_tag;
  logic                busy;

  modport master (
    output in_valid, in_mode, in_state, in_tag, out_ready,
    input  in_ready, out_valid, out_state, out_tag, busy
  );

  modport slave (
    input  in_valid, in_mode, in_state, in_tag, out_ready,
    output in_ready, out_valid, out_state, out_tag, busy
  );
endinterface

// File: rtl/shiftrow_pipe.sv
// Registered Rijndael ShiftRows / InvShiftRows / bypass stage for Nb = 4, 6 or 8,
// with a 2-entry output FIFO so the stage sustains one block per cycle under backpressure.
module shiftrow_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  shiftrow_if.slave  bus
);

  localparam int SW = 32 * NB;

  typedef logic [0:SW-1] state_t;

  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'b00,
    MODE_FWD     = 2'b01,
    MODE_INV     = 2'b10,
    MODE_BYPASS2 = 2'b11
  } mode_e;

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shiftrow_pipe: NB must be 4, 6 or 8");
    end
  endgenerate

  // Rijndael uses a larger shift on rows 2 and 3 only for the 256-bit block.
  function automatic int row_shift(input int r);
    return (NB == 8 && r >= 2) ? r + 1 : r;
  endfunction

  // ---------------------------------------------------------------------------
  // Input-side permutation
  // ---------------------------------------------------------------------------
  state_t perm_state;
  mode_e  mode;

  assign mode = mode_e'(bus.in_mode);

  // NOTE: every variable written in a combinational block gets a default first,
  // otherwise an unlisted path holds its old value and a latch is inferred.
  always_comb begin
    perm_state = bus.in_state;
    case (mode)
      MODE_FWD: begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < NB; c++) begin
            perm_state[8*(4*c+r) +: 8] = bus.in_state[8*(4*((c + row_shift(r)) % NB) + r) +: 8];
          end
        end
      end
      MODE_INV: begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < NB; c++) begin
            perm_state[8*(4*c+r) +: 8] = bus.in_state[8*(4*((c + NB - row_shift(r)) % NB) + r) +: 8];
          end
        end
      end
      default: perm_state = bus.in_state;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Two-entry output FIFO
  // ---------------------------------------------------------------------------
  state_t           mem_q [2];
  state_t           mem_d [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [TAG_W-1:0] tag_d [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             live_q, live_d;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = bus.in_valid  & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  always_comb begin
    mem_d   = mem_q;
    tag_d   = tag_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    live_d  = 1'b1;

    if (in_xfer) begin
      mem_d[tail_q] = perm_state;
      tag_d[tail_q] = bus.in_tag;
      tail_d        = ~tail_q;
    end
    if (out_xfer) begin
      head_d = ~head_q;
    end

    case ({in_xfer, out_xfer})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the buffer storage is reset too, so out_state reads zero after
      // reset rather than whatever the RAM-like array powered up with.
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
        tag_q[i] <= '0;
      end
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      live_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      tag_q   <= tag_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      live_q  <= live_d;
    end
  end

  // live_q keeps in_ready low while reset is held and releases it on the first clock after.
  assign bus.in_ready  = live_q & (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.busy      = (count_q != 2'd0);
  assign bus.out_state = mem_q[head_q];
  assign bus.out_tag   = tag_q[head_q];

endmodule
